// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-add multiplier that borrows the LEGv8 ALU for every add and shift step
module alu_mul_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplr_in,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             carry_flag,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [4:0]       alu_FS,
  output logic             alu_C0,
  input  logic [WIDTH-1:0] alu_F,
  input  logic [3:0]       alu_status
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [4:0] FS_OR = 5'b00100, FS_ADD = 5'b01000, FS_LSL = 5'b10000,
                         FS_LSR = 5'b10100, FS_ZERO = 5'b11000;
  typedef enum logic [2:0] {IDLE, CHECK, ADD, SHL, SHR, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplr_q, mplr_d, prod_q, prod_d, a_d, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_d;
  logic [4:0] fs_d;
  logic unused_ok;
  assign unused_ok = ^{alu_status[3], alu_status[1]};
  assign alu_C0 = 1'b0;
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    carry_d = carry_flag;
    case (state_q)
      IDLE: if (start) begin
        mcand_d = mcand_in;
        mplr_d  = mplr_in;
        prod_d  = '0;
        cnt_d   = '0;
        carry_d = 1'b0;
        state_d = CHECK;
      end
      CHECK: state_d = (alu_status[0] || cnt_q == CW'(WIDTH)) ? DONE : mplr_q[0] ? ADD : SHL;
      ADD: begin
        prod_d  = alu_F;
        carry_d = carry_flag | alu_status[2];
        state_d = SHL;
      end
      SHL: begin
        mcand_d = alu_F;
        state_d = SHR;
      end
      SHR: begin
        mplr_d  = alu_F;
        cnt_d   = cnt_q + 1'b1;
        state_d = CHECK;
      end
      DONE: if (result_ack && result_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // ALU drive is registered, so it is derived from the state and operands of the coming cycle
    a_d  = (state_d == CHECK || state_d == SHR) ? mplr_d :
           (state_d == ADD) ? prod_d : (state_d == SHL) ? mcand_d : '0;
    b_d  = (state_d == ADD) ? mcand_d : (state_d == SHL || state_d == SHR) ? WIDTH'(1) : '0;
    fs_d = (state_d == CHECK) ? FS_OR : (state_d == ADD) ? FS_ADD :
           (state_d == SHL) ? FS_LSL : (state_d == SHR) ? FS_LSR : FS_ZERO;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      mcand_q      <= '0;
      mplr_q       <= '0;
      prod_q       <= '0;
      cnt_q        <= '0;
      carry_flag   <= 1'b0;
      ready        <= 1'b1;
      result       <= '0;
      result_valid <= 1'b0;
      alu_A        <= '0;
      alu_B        <= '0;
      alu_FS       <= FS_ZERO;
    end else begin
      state_q      <= state_d;
      mcand_q      <= mcand_d;
      mplr_q       <= mplr_d;
      prod_q       <= prod_d;
      cnt_q        <= cnt_d;
      carry_flag   <= carry_d;
      ready        <= state_d == IDLE;
      result       <= (state_q == DONE && !result_valid) ? prod_q : result;
      result_valid <= state_q == DONE && state_d == DONE;
      alu_A        <= a_d;
      alu_B        <= b_d;
      alu_FS       <= fs_d;
    end
  end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: scoreboard bench with a behavioural LEGv8 ALU and product/latency model
module tb_alu_mul_sequencer;
  typedef struct packed {logic [63:0] res; logic cy; int lat;} exp_t;
  logic clock = 0, reset = 1, start = 0, result_ack = 0;
  logic [63:0] mcand_in = '0, mplr_in = '0, result, alu_A, alu_B, alu_F, ax, by;
  logic [64:0] asum;
  logic ready, result_valid, carry_flag, alu_C0, pv = 0;
  logic [4:0] alu_FS;
  logic [3:0] alu_status;
  logic [63:0] held;
  exp_t sbq[$];
  exp_t mon_e;
  int total = 0, bad = 0, cyc = 0, acc_cyc = 0;

  alu_mul_sequencer #(.WIDTH(64)) dut (
    .clock(clock), .reset(reset), .start(start), .ready(ready),
    .mcand_in(mcand_in), .mplr_in(mplr_in), .result(result), .result_valid(result_valid),
    .result_ack(result_ack), .carry_flag(carry_flag), .alu_A(alu_A), .alu_B(alu_B),
    .alu_FS(alu_FS), .alu_C0(alu_C0), .alu_F(alu_F), .alu_status(alu_status));

  always #5 clock = ~clock;

  always_comb begin
    ax   = alu_FS[1] ? ~alu_A : alu_A;
    by   = alu_FS[0] ? ~alu_B : alu_B;
    asum = {1'b0, ax} + {1'b0, by} + {64'b0, alu_C0};
    case (alu_FS[4:2])
      3'd0: alu_F = ax & by;
      3'd1: alu_F = ax | by;
      3'd2: alu_F = asum[63:0];
      3'd3: alu_F = ax ^ by;
      3'd4: alu_F = ax << by[5:0];
      3'd5: alu_F = ax >> by[5:0];
      default: alu_F = '0;
    endcase
    alu_status = {alu_FS[4:2] == 3'd2 && ax[63] == by[63] && asum[63] != ax[63],
                  alu_FS[4:2] == 3'd2 && asum[64], alu_F[63], alu_F == 64'd0};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout or unexpected event", nm);
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    logic [63:0] acc = '0;
    int k = -1, pop = 0;
    model.cy = 1'b0;
    for (int i = 0; i < 64; i++)
      if (b[i]) begin
        s = {1'b0, acc} + {1'b0, a << i};
        model.cy |= s[64];
        acc = s[63:0];
        k = i;
        pop++;
      end
    model.res = a * b;
    model.lat = 2 + 3 * (k + 1) + pop;
  endfunction

  always @(posedge clock) begin
    cyc++;
    if (start && ready && !reset) acc_cyc = cyc;
  end

  always @(negedge clock) begin
    if (reset) begin
      sbq.delete();
      pv = 0;
    end else begin
      if (result_valid && !pv) begin
        if (sbq.size() == 0) fail("unexpected_valid");
        else begin
          mon_e = sbq.pop_front();
          chk("result", result, mon_e.res);
          chk("carry_flag", {63'b0, carry_flag}, {63'b0, mon_e.cy});
          chk("latency", cyc - acc_cyc, mon_e.lat);
          held = result;
        end
      end else if (result_valid) chk("result_stable", result, held);
      pv = result_valid;
    end
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    while (!ready && n < 400) begin @(negedge clock); n++; end
    if (!ready) fail("ready_wait");
    start = 1; mcand_in = a; mplr_in = b;
    sbq.push_back(model(a, b));
    @(negedge clock);
    start = 0;
  endtask

  task automatic run(input logic [63:0] a, input logic [63:0] b, input int hold);
    logic [4:0] fsq[$], efs[$];
    int n = 0, k = -1;
    issue(a, b);
    for (int i = 0; i < 64; i++) if (b[i]) k = i;
    for (int i = 0; i <= k; i++) begin
      efs.push_back(5'h04);
      if (b[i]) efs.push_back(5'h08);
      efs.push_back(5'h10);
      efs.push_back(5'h14);
    end
    efs.push_back(5'h04);
    while (!result_valid && n < 400) begin
      if (alu_FS != 5'h18) fsq.push_back(alu_FS);
      start = 1'($urandom_range(0, 1));
      mcand_in = {$urandom, $urandom};
      mplr_in = {$urandom, $urandom};
      @(negedge clock);
      n++;
    end
    if (!result_valid) fail("valid_wait");
    else begin
      chk("fs_count", fsq.size(), efs.size());
      for (int i = 0; i < fsq.size() && i < efs.size(); i++) chk("fs_seq", {59'b0, fsq[i]}, {59'b0, efs[i]});
    end
    start = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("busy_ready", {63'b0, ready}, 64'd0);
    end
    result_ack = 1;
    @(negedge clock);
    result_ack = 0;
    start = 0;
    chk("valid_drop", {63'b0, result_valid}, 64'd0);
    chk("ready_rise", {63'b0, ready}, 64'd1);
    @(negedge clock);
    chk("no_accept_on_ack", {63'b0, ready}, 64'd1);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_ready"}, {63'b0, ready}, 64'd1);
    chk({nm, "_valid"}, {63'b0, result_valid}, 64'd0);
    chk({nm, "_result"}, result, 64'd0);
    chk({nm, "_carry"}, {63'b0, carry_flag}, 64'd0);
    chk({nm, "_alu"}, {alu_A ^ alu_B, 5'b0, alu_FS, alu_C0}, {64'd0, 5'b0, 5'h18, 1'b0});
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk_idle("reset");
    reset = 0;
    @(negedge clock);
    run(64'd3, 64'd5, 2);
    run(64'h1234, 64'd0, 0);
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1);
    run(64'd1, 64'h8000_0000_0000_0000, 0);
    issue(64'd7, 64'd9);
    repeat (4) @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk_idle("abort");
    run(64'd2, 64'd2, 10);
    for (int t = 0; t < 25; t++)
      run({$urandom, $urandom}, {$urandom, $urandom} >> $urandom_range(0, 63), $urandom_range(0, 3));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
